etai_accumulator: RTL and testbench
===================================

Name: etai_accumulator

Overview:
- Sequential accumulation stage that consumes products from the PE multiplier array.
- Each product is added into a running accumulator using Error Tolerant Adder Type I (ETA-I) arithmetic over ACC_W bits. The low BORDER bits are approximate; the upper bits are exact.
- The stage accepts a burst of LEN operands over a valid/ready stream, then presents one result on a valid/ready output.
- It sits between the multiplier stage and the activation/requantize stage of each DNN processing element.

Parameters:
DATA_W, 8, operand width; operands are zero-extended to ACC_W
ACC_W, 16, accumulator and result width; must satisfy ACC_W >= DATA_W and ACC_W > BORDER
BORDER, 2, number of approximate LSBs; 0 gives exact addition
LEN_W, 8, width of the burst-length input

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin burst; sampled only in IDLE
len  input  LEN_W  number of operands in the burst; sampled with start
in_valid  input  1  operand valid
in_ready  output  1  operand accepted when in_valid && in_ready
in_data  input  DATA_W  operand (unsigned)
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready
out_data  output  ACC_W  accumulated result
out_overflow  output  1  sticky flag: saturation occurred during this burst

Behaviour:
- One clock; reset is synchronous and active-high. On clk rising edge with rst=1, all of the following take effect in that cycle:
  - state=IDLE
  - acc=0, count=0, ovf=0
  - in_ready=0, out_valid=0, out_data=0, out_overflow=0
- Reset mid-burst discards the burst. No output is produced for it.
- ETA-I add f(A,B) over ACC_W bits:
  - Approximate region, bits BORDER-1 down to 0: scan from bit BORDER-1 toward bit 0. At the first bit where A[i]&B[i]=1, that bit and every lower bit are 1. Above that point, s[i]=A[i]|B[i]. The region generates no carry.
  - Accurate region: {cout, s[ACC_W-1:BORDER]} = A[ACC_W-1:BORDER] + B[ACC_W-1:BORDER], with carry-in 0.
  - If cout=1, the result saturates to all-ones and ovf is set. ovf is sticky until the next start.
- State IDLE:
  - in_ready=0, out_valid=0.
  - When start=1: acc<=0, ovf<=0, count<=len.
  - If len==0, go to DONE; otherwise go to ACCUM.
- State ACCUM:
  - in_ready=1 (registered, asserted the cycle after start).
  - On each handshake: acc<=f(acc, zext(in_data)) and count<=count-1.
  - When the handshake consumes the last operand (count==1), go to DONE.
  - in_valid low stalls with no change to acc or count.
- State DONE:
  - out_valid=1, out_data=acc, out_overflow=ovf. These are held stable while out_ready=0.
  - On an output handshake, go to IDLE. out_valid=0 the next cycle.
- start is ignored outside IDLE.
- start asserted in the same cycle as the output handshake is also ignored. The earliest accepted start is the first IDLE cycle.
- Latency:
  - Last operand accepted at cycle t gives out_valid at t+1.
  - With len==0, start at cycle t gives out_valid at t+1 with out_data=0.
- Throughput: one operand per cycle in ACCUM. in_data is don't-care when in_valid=0.
- Saturated acc continues to accumulate. Further saturation keeps the result at all-ones.

Test Plan:
- Reset with defaults; wait 3 cycles -> in_ready=0, out_valid=0, out_data=0, out_overflow=0.
- start, len=2; data 5 then 6 -> out_data=11, out_overflow=0; out_valid exactly 1 cycle after the 2nd handshake.
- start, len=2; data 3 then 1 -> out_data=3 (exact sum is 4; approximate error).
- start, len=2; data 2 then 2 -> out_data=3.
- Same burst with BORDER=0 (len=2, data 2 then 2) -> out_data=4.
- Saturation: ACC_W=16, DATA_W=16, start len=2; data 0xFFFC then 0x0004 -> out_data=0xFFFF, out_overflow=1.
  - Follow with a new burst len=1, data 7 -> out_data=7, out_overflow=0.
- Handshake stress:
  - len=3, in_valid toggled randomly, out_ready held 0 for 5 cycles -> out_data/out_overflow stable while held.
  - start pulsed during ACCUM and DONE is ignored.
  - len=0 gives out_data=0 one cycle after start.
  - rst asserted after the 2nd operand gives IDLE next cycle with no out_valid.

Source files
------------

// File: rtl/etai_accumulator.sv
// etai_accumulator: burst accumulator using ETA-I approximate addition with saturation
module etai_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int BORDER = 2,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, nxt;
  logic [ACC_W-1:0] acc, sum;
  logic [LEN_W-1:0] count;
  logic ovf;
  logic [ACC_W:0] add_r;
  // returns {carry_out, approximate sum}; low region never carries upward
  function automatic logic [ACC_W:0] eta_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] hi;
    logic [ACC_W-1:0] lo;
    logic hit;
    lo = '0;
    hit = 1'b0;
    for (int i = BORDER - 1; i >= 0; i--) begin
      hit = hit | (a[i] & b[i]);
      lo[i] = hit | a[i] | b[i];
    end
    hi = ({1'b0, a} >> BORDER) + ({1'b0, b} >> BORDER);
    return {hi[ACC_W-BORDER], (hi[ACC_W-1:0] << BORDER) | lo};
  endfunction
  assign add_r = eta_add(acc, ACC_W'(in_data));
  assign sum = add_r[ACC_W] ? '1 : add_r[ACC_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        acc <= '0;
        ovf <= 1'b0;
        count <= len;
      end else if (state == ACCUM && in_valid) begin
        acc <= sum;
        ovf <= ovf | add_r[ACC_W];
        count <= count - 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state;
    in_ready = state == ACCUM;
    out_valid = state == DONE;
    out_data = out_valid ? acc : '0;
    out_overflow = out_valid & ovf;
    case (state)
      IDLE:    nxt = start ? (len == '0 ? DONE : ACCUM) : IDLE;
      ACCUM:   nxt = (in_valid && count == LEN_W'(1)) ? DONE : ACCUM;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_etai_accumulator.sv
// tb_etai_accumulator: two configurations run in lockstep against an arithmetic ETA-I model
module tb_etai_accumulator;
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [7:0] len;
  logic [15:0] in_data;
  logic rdy_a, vld_a, ov_a, rdy_b, vld_b, ov_b;
  logic [15:0] dat_a, dat_b;
  int n_cmp = 0, n_err = 0;
  int ops[$];
  int got_a, got_b, gov_a, gov_b;
  always #5 clk = ~clk;
  etai_accumulator u_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data[7:0]),
    .out_valid(vld_a), .out_ready(out_ready), .out_data(dat_a), .out_overflow(ov_a)
  );
  etai_accumulator #(.DATA_W(16), .ACC_W(16), .BORDER(0), .LEN_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .out_valid(vld_b), .out_ready(out_ready), .out_data(dat_b), .out_overflow(ov_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int eta(input int a, input int b, input int bd, input int w, output bit sat);
    int m, lo, both, k, hi;
    m = (1 << bd) - 1;
    lo = (a | b) & m;
    both = a & b & m;
    k = 0;
    while (both > 0) begin
      both = both >> 1;
      k++;
    end
    lo = lo | ((1 << k) - 1);
    hi = (a >> bd) + (b >> bd);
    sat = hi >= (1 << (w - bd));
    return sat ? (1 << w) - 1 : (hi << bd) | lo;
  endfunction
  function automatic int ref_acc(input int bd, input int w, input int dm, output bit ov);
    int acc;
    bit s;
    acc = 0;
    ov = 0;
    foreach (ops[i]) begin
      acc = eta(acc, ops[i] & dm, bd, w, s);
      ov = ov | s;
    end
    return acc;
  endfunction
  task automatic burst(input int n, input bit stress);
    int ea, eb, idx, budget, hold;
    bit ea_ov, eb_ov, v;
    ea = ref_acc(2, 16, 'hff, ea_ov);
    eb = ref_acc(0, 16, 'hffff, eb_ov);
    @(negedge clk);
    start = 1'b1;
    len = 8'(n);
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    budget = 0;
    while (idx < n && budget < 200) begin
      check("in_ready", {rdy_a, rdy_b}, 2'b11);
      v = stress ? ($urandom_range(3) != 0) : 1'b1;
      in_valid = v;
      in_data = v ? 16'(ops[idx]) : 16'($urandom);
      if (stress) start = 1'($urandom_range(1));
      @(negedge clk);
      if (v) idx++;
      budget++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (idx < n) check("accum_timeout", idx, n);
    check("lat_valid", {vld_a, vld_b}, 2'b11);
    hold = stress ? 5 : $urandom_range(2);
    for (int k = 0; k <= hold; k++) begin
      if (k == 0) begin
        got_a = dat_a; gov_a = ov_a; got_b = dat_b; gov_b = ov_b;
      end
      check("hold_valid", {vld_a, vld_b}, 2'b11);
      check("data_a", dat_a, ea);
      check("ovf_a", ov_a, ea_ov);
      check("data_b", dat_b, eb);
      check("ovf_b", ov_b, eb_ov);
      out_ready = k == hold;
      start = stress ? 1'($urandom_range(1)) | (k == hold) : 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
    start = 1'b0;
    check("valid_drop", {vld_a, vld_b}, 2'b00);
    @(negedge clk);
    check("idle", {rdy_a, vld_a, rdy_b, vld_b}, 4'b0);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {rdy_a, vld_a, rdy_b, vld_b}, 4'b0);
    check("rst_data", {dat_a, dat_b}, 0);
    check("rst_ovf", {ov_a, ov_b}, 2'b00);
    rst = 1'b0;
    ops = '{5, 6};
    burst(2, 0);
    check("d_5_6", got_a, 11);
    check("d_5_6_ovf", gov_a, 0);
    ops = '{3, 1};
    burst(2, 0);
    check("d_3_1", got_a, 3);
    ops = '{2, 2};
    burst(2, 0);
    check("d_2_2_b2", got_a, 3);
    check("d_2_2_b0", got_b, 4);
    ops = '{'hfffc, 4};
    burst(2, 0);
    check("sat_data", got_b, 'hffff);
    check("sat_ovf", gov_b, 1);
    ops = '{7};
    burst(1, 0);
    check("post_sat", got_b, 7);
    check("post_sat_ovf", gov_b, 0);
    ops.delete();
    burst(0, 0);
    check("len0", got_a, 0);
    ops = '{$urandom_range(255), $urandom_range(255), $urandom_range(255)};
    burst(3, 1);
    ops = '{1, 2, 3, 4};
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 16'd1;
    @(negedge clk);
    in_data = 16'd2;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst", {rdy_a, vld_a, rdy_b, vld_b}, 4'b0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_quiet", {rdy_a, vld_a, rdy_b, vld_b}, 4'b0);
    end
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(6);
      ops.delete();
      for (int i = 0; i < n; i++) ops.push_back($urandom_range('hffff));
      burst(n, 1'($urandom_range(1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
